sdp_bram_clr: RTL and testbench
===============================

Name: sdp_bram_clr

Overview:
Single-clock simple dual-port BRAM: one write port, one read port. Adds byte-lane write enables, a read-valid pipeline with configurable read latency, and optional same-cycle write-to-read forwarding. On reset, a sequencer sweeps every address to zero, so table state is deterministic after every reset, not only at configuration. Used for per-queue metadata and rank tables inside the scheduler datapath.

Parameters:
RAM_WIDTH, 32, data word width; must be an integer multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, width of one write-enable lane; NB = RAM_WIDTH/BYTE_WIDTH.
L2_RAM_DEPTH, 10, address width; DEPTH = 2**L2_RAM_DEPTH.
READ_LATENCY, 2, read latency in cycles; legal values are 1 or 2.
FWD_EN, 1, 1 = write-first on same-cycle address collision; 0 = read-first (old data).
CLEAR_ON_RESET, 1, 1 = zero-sweep the whole array after reset; 0 = no sweep, contents retained.

Ports:
clka  input  1  clock for all logic
rstb  input  1  synchronous reset, active-high
wea  input  1  write request
bwea  input  NB  byte-lane enables, qualified by wea
addra  input  L2_RAM_DEPTH  write address
dina  input  RAM_WIDTH  write data
enb  input  1  read request
addrb  input  L2_RAM_DEPTH  read address
doutb  output  RAM_WIDTH  read data
doutb_valid  output  1  one-cycle pulse per accepted read
init_busy  output  1  high while the clear sweep runs; port requests are ignored

Behaviour:
- Reset and clock: rstb is synchronous, active-high; all logic is clocked by clka.
- Reset values: doutb=0, doutb_valid=0, all pipeline valid bits=0, clr_addr=0.
  - CLEAR_ON_RESET=1: state=CLEAR, init_busy=1.
  - CLEAR_ON_RESET=0: state=RUN, init_busy=0.
  - RAM contents are not altered by rstb itself.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle write 0 to RAM[clr_addr] (all lanes), then clr_addr++.
  - When clr_addr==DEPTH-1 that write completes and state goes to RUN on the same edge.
  - init_busy is therefore high for exactly DEPTH cycles after the rstb-low edge.
  - RUN: stays in RUN until rstb.
- Reset mid-sweep: restarts the sweep at address 0; busy is held continuously.
- Requests while busy: wea and enb are ignored (dropped, not queued). No doutb_valid results from a read issued while busy.
- Write (RUN, wea=1): for each lane i with bwea[i]=1, RAM[addra] lane i <= dina lane i.
  - Lanes with bwea[i]=0 are unchanged.
  - wea=1 with bwea=0 is a no-op.
- Read (RUN, enb=1): stage 1 registers RAM[addrb] plus v1=1.
  - READ_LATENCY=2: stage 2 registers stage 1 when v1=1, plus v2=v1.
  - doutb/doutb_valid come from the last stage.
  - Latency is exactly READ_LATENCY edges from the enb edge to doutb_valid high.
  - Back-to-back reads are accepted every cycle; full throughput.
- doutb holds its last value when no valid read arrives; it is never cleared except by rstb. doutb_valid is high one cycle per read.
- Collision (wea=1, enb=1, addra==addrb, same cycle):
  - FWD_EN=1: stage 1 data = old word with enabled lanes replaced by dina lanes.
  - FWD_EN=0: stage 1 data = old word.
- A read in the cycle after a write to the same address always returns the new data, independent of FWD_EN.
- Reads of addresses never written after a sweep return 0.
- Address arithmetic: clr_addr is L2_RAM_DEPTH+0 bits wide and wrap is not reachable because the FSM exits at DEPTH-1. addra and addrb are used unmodified.
- Illegal READ_LATENCY or width ratio: elaboration error via a generate-time check.

Test Plan:
- Clear sweep: L2_RAM_DEPTH=4, preload RAM[5]=0xDEADBEEF, pulse rstb 1 cycle -> init_busy high exactly 16 cycles; afterwards reading addr 5 returns 0x00000000 with doutb_valid 2 cycles after enb.
- Busy drop: during sweep, wea=1 addr=3 dina=0x11223344 and enb=1 -> no doutb_valid; after busy, read addr 3 returns 0.
- Byte lanes: RAM[7]=0xAABBCCDD, write bwea=4'b0101 dina=0x11223344 -> read addr 7 returns 0xAA22CC44.
- Collision: RAM[2]=0x0, same-cycle write 0x12345678 (bwea=4'hF) and read addr 2 -> FWD_EN=1 returns 0x12345678; FWD_EN=0 returns 0x00000000; read next cycle returns 0x12345678 in both cases.
- Latency and throughput: READ_LATENCY=1 and 2, enb high 4 cycles on addrs 0..3 holding 0x10..0x13 -> 4 consecutive valid pulses starting 1 or 2 cycles later, data in order; doutb holds 0x13 afterwards.
- Mid-sweep reset: assert rstb at sweep cycle 9 -> busy stays high, total busy = 9 + 16 cycles, all addresses read 0.

Source files
------------

// File: rtl/sdp_bram_clr.sv
// Simple dual-port block RAM with byte-lane writes, 1- or 2-cycle read pipeline,
// optional write-first forwarding and a zero-fill sweep that runs after every reset.
module sdp_bram_clr #(
    parameter int unsigned RAM_WIDTH      = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned L2_RAM_DEPTH   = 10,
    parameter int unsigned READ_LATENCY   = 2,
    parameter bit          FWD_EN         = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                              clka,
    input  logic                              rstb,
    input  logic                              wea,
    input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]   bwea,
    input  logic [L2_RAM_DEPTH-1:0]           addra,
    input  logic [RAM_WIDTH-1:0]              dina,
    input  logic                              enb,
    input  logic [L2_RAM_DEPTH-1:0]           addrb,
    output logic [RAM_WIDTH-1:0]              doutb,
    output logic                              doutb_valid,
    output logic                              init_busy
);

    localparam int unsigned NB = RAM_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** L2_RAM_DEPTH;
    localparam logic [L2_RAM_DEPTH-1:0] LAST_ADDR = {L2_RAM_DEPTH{1'b1}};

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gen_bad_latency
        $error("sdp_bram_clr: READ_LATENCY must be 1 or 2");
    end
    if (NB == 0 || NB * BYTE_WIDTH != RAM_WIDTH) begin : gen_bad_width
        $error("sdp_bram_clr: RAM_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e                    state_q;
    logic [L2_RAM_DEPTH-1:0]   clr_addr_q;
    logic                      init_busy_q;

    always_ff @(posedge clka) begin
        if (rstb) begin
            clr_addr_q <= '0;
            if (CLEAR_ON_RESET) begin
                state_q     <= StClear;
                init_busy_q <= 1'b1;
            end else begin
                state_q     <= StRun;
                init_busy_q <= 1'b0;
            end
        end else begin
            unique case (state_q)
                StClear: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q     <= StRun;
                        init_busy_q <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + L2_RAM_DEPTH'(1);
                    end
                end
                StRun: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign init_busy = init_busy_q;

    // Port traffic is only honoured in RUN and never on a reset cycle.
    logic clr_we;
    logic wr_en;
    logic rd_en;
    assign clr_we = (state_q == StClear) && !rstb;
    assign wr_en  = (state_q == StRun) && !rstb && wea;
    assign rd_en  = (state_q == StRun) && !rstb && enb;

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clka) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bwea[i]) begin
                    mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-first merge: enabled lanes of a same-address write replace the old word.
    logic [RAM_WIDTH-1:0] rd_word;
    always_comb begin
        rd_word = mem[addrb];
        if (FWD_EN && wr_en && (addra == addrb)) begin
            for (int i = 0; i < NB; i++) begin
                if (bwea[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [RAM_WIDTH-1:0] rd1_q;
    logic                 v1_q;

    always_ff @(posedge clka) begin
        if (rstb) begin
            rd1_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= rd_en;
            if (rd_en) begin
                rd1_q <= rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : gen_lat2
        logic [RAM_WIDTH-1:0] rd2_q;
        logic                 v2_q;

        always_ff @(posedge clka) begin
            if (rstb) begin
                rd2_q <= '0;
                v2_q  <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    rd2_q <= rd1_q;
                end
            end
        end

        assign doutb       = rd2_q;
        assign doutb_valid = v2_q;
    end else begin : gen_lat1
        assign doutb       = rd1_q;
        assign doutb_valid = v1_q;
    end

endmodule

// File: tb/tb_sdp_bram_clr.sv
// Bench for sdp_bram_clr: a write-first/2-cycle and a read-first/1-cycle instance share
// stimulus; per-instance queues hold expected read results with their due cycle.
module tb_sdp_bram_clr;

    typedef struct {
        logic        we;
        logic [3:0]  bwe;
        logic [3:0]  wa;
        logic [31:0] din;
        logic        re;
        logic [3:0]  ra;
        logic        acc;
        logic [31:0] e_fwd;
        logic [31:0] e_nofwd;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clka = 1'b0;
    logic        rstb = 1'b1;
    logic        wea = 1'b0;
    logic        enb = 1'b0;
    logic [3:0]  bwea = 4'h0;
    logic [3:0]  addra = 4'h0;
    logic [3:0]  addrb = 4'h0;
    logic [31:0] dina = 32'h0;

    logic [31:0] doutb_f, doutb_r, doutb_n;
    logic        valid_f, valid_r, valid_n;
    logic        busy_f, busy_r, busy_n;

    sdp_bram_clr #(
        .RAM_WIDTH(32), .BYTE_WIDTH(8), .L2_RAM_DEPTH(4), .READ_LATENCY(2),
        .FWD_EN(1'b1), .CLEAR_ON_RESET(1'b1)
    ) u_fwd (
        .clka(clka), .rstb(rstb), .wea(wea), .bwea(bwea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb_f), .doutb_valid(valid_f), .init_busy(busy_f)
    );

    sdp_bram_clr #(
        .RAM_WIDTH(32), .BYTE_WIDTH(8), .L2_RAM_DEPTH(4), .READ_LATENCY(1),
        .FWD_EN(1'b0), .CLEAR_ON_RESET(1'b1)
    ) u_rdf (
        .clka(clka), .rstb(rstb), .wea(wea), .bwea(bwea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb_r), .doutb_valid(valid_r), .init_busy(busy_r)
    );

    sdp_bram_clr #(
        .RAM_WIDTH(32), .BYTE_WIDTH(8), .L2_RAM_DEPTH(4), .READ_LATENCY(2),
        .FWD_EN(1'b1), .CLEAR_ON_RESET(1'b0)
    ) u_nclr (
        .clka(clka), .rstb(rstb), .wea(wea), .bwea(bwea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb_n), .doutb_valid(valid_n), .init_busy(busy_n)
    );

    always #5 clka = ~clka;

    int cyc = 0;
    int busy_cnt = 0;
    int errors = 0;
    int checks = 0;
    logic armed = 1'b0;
    exp_t q [2][$];
    logic [31:0] last_exp [2];

    always @(posedge clka) cyc <= cyc + 1;

    // Independent busy model: 16 busy cycles counted from the last reset edge.
    always @(posedge clka) begin
        if (rstb) busy_cnt <= 16;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [31:0] dat);
        exp_t e;
        if (q[d].size() != 0 && q[d][0].due == cyc) begin
            e = q[d].pop_front();
            chk($sformatf("valid_pulse[%0d]", d), 32'(v), 32'd1);
            chk($sformatf("read_data[%0d]", d), dat, e.data);
            last_exp[d] = e.data;
        end else begin
            chk($sformatf("valid_idle[%0d]", d), 32'(v), 32'd0);
            chk($sformatf("dout_hold[%0d]", d), dat, last_exp[d]);
        end
    endtask

    always @(negedge clka) begin
        if (armed) begin
            mon(0, valid_f, doutb_f);
            mon(1, valid_r, doutb_r);
            chk("busy_fwd", 32'(busy_f), 32'(busy_cnt != 0));
            chk("busy_rdf", 32'(busy_r), 32'(busy_cnt != 0));
            chk("busy_noclear", 32'(busy_n), 32'd0);
        end
    end

    function automatic vec_t mk(input logic we, input logic [3:0] bwe, input logic [3:0] wa,
                                input logic [31:0] din, input logic re, input logic [3:0] ra,
                                input logic acc, input logic [31:0] ef, input logic [31:0] en);
        vec_t v;
        v.we = we; v.bwe = bwe; v.wa = wa; v.din = din;
        v.re = re; v.ra = ra; v.acc = acc; v.e_fwd = ef; v.e_nofwd = en;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        wea = v.we; bwea = v.bwe; addra = v.wa; dina = v.din; enb = v.re; addrb = v.ra;
        if (v.re && v.acc) begin
            e.due = cyc + 2; e.data = v.e_fwd;
            q[0].push_back(e);
            e.due = cyc + 1; e.data = v.e_nofwd;
            q[1].push_back(e);
        end
        @(posedge clka);
        #1;
        wea = 1'b0; enb = 1'b0; bwea = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(mk(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 32'h0, 32'h0));
    endtask

    task automatic pulse_reset();
        rstb = 1'b1;
        @(posedge clka);
        #1;
        rstb = 1'b0;
        last_exp[0] = 32'h0;
        last_exp[1] = 32'h0;
    endtask

    task automatic count_busy(output int nf, output int nr);
        nf = 0; nr = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clka);
            nf += int'(busy_f);
            nr += int'(busy_r);
            if (!busy_f && !busy_r) break;
        end
        @(posedge clka);
        #1;
    endtask

    vec_t tbl [20];

    initial begin
        int nf, nr, mf, mr;
        // Multi-lane, forwarding, latency and hold cases applied after the first sweep.
        tbl[0]  = mk(1, 4'hF, 4'd5, 32'hDEADBEEF, 1, 4'd3, 1, 32'h0,        32'h0);
        tbl[1]  = mk(1, 4'hF, 4'd7, 32'hAABBCCDD, 1, 4'd5, 1, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[2]  = mk(1, 4'h5, 4'd7, 32'h11223344, 1, 4'd7, 1, 32'hAA22CC44, 32'hAABBCCDD);
        tbl[3]  = mk(0, 4'h0, 4'd0, 32'h0,        1, 4'd7, 1, 32'hAA22CC44, 32'hAA22CC44);
        tbl[4]  = mk(1, 4'h0, 4'd7, 32'hFFFFFFFF, 1, 4'd7, 1, 32'hAA22CC44, 32'hAA22CC44);
        tbl[5]  = mk(0, 4'h0, 4'd0, 32'h0,        1, 4'd7, 1, 32'hAA22CC44, 32'hAA22CC44);
        tbl[6]  = mk(0, 4'h0, 4'd0, 32'h0,        1, 4'd9, 1, 32'h0,        32'h0);
        tbl[7]  = mk(1, 4'hF, 4'd2, 32'h12345678, 1, 4'd2, 1, 32'h12345678, 32'h0);
        tbl[8]  = mk(0, 4'h0, 4'd0, 32'h0,        1, 4'd2, 1, 32'h12345678, 32'h12345678);
        tbl[9]  = mk(1, 4'hF, 4'd0, 32'h10,       0, 4'd0, 0, 32'h0,        32'h0);
        tbl[10] = mk(1, 4'hF, 4'd1, 32'h11,       0, 4'd0, 0, 32'h0,        32'h0);
        tbl[11] = mk(1, 4'hF, 4'd2, 32'h12,       0, 4'd0, 0, 32'h0,        32'h0);
        tbl[12] = mk(1, 4'hF, 4'd3, 32'h13,       0, 4'd0, 0, 32'h0,        32'h0);
        tbl[13] = mk(0, 4'h0, 4'd0, 32'h0,        1, 4'd0, 1, 32'h10,       32'h10);
        tbl[14] = mk(0, 4'h0, 4'd0, 32'h0,        1, 4'd1, 1, 32'h11,       32'h11);
        tbl[15] = mk(0, 4'h0, 4'd0, 32'h0,        1, 4'd2, 1, 32'h12,       32'h12);
        tbl[16] = mk(0, 4'h0, 4'd0, 32'h0,        1, 4'd3, 1, 32'h13,       32'h13);
        tbl[17] = mk(0, 4'h0, 4'd0, 32'h0,        0, 4'd0, 0, 32'h0,        32'h0);
        tbl[18] = mk(1, 4'h8, 4'd8, 32'h55AA55AA, 1, 4'd8, 1, 32'h55000000, 32'h0);
        tbl[19] = mk(0, 4'h0, 4'd0, 32'h0,        1, 4'd8, 1, 32'h55000000, 32'h55000000);

        repeat (2) @(posedge clka);
        #1;
        rstb = 1'b0;
        last_exp[0] = 32'h0;
        last_exp[1] = 32'h0;
        chk("noclear_reset_dout", doutb_n, 32'h0);
        chk("noclear_reset_valid", 32'(valid_n), 32'd0);
        armed = 1'b1;

        // Requests late in the sweep (after address 3 was cleared) must be dropped.
        idle(10);
        for (int i = 0; i < 3; i++)
            apply(mk(1, 4'hF, 4'd3, 32'h11223344, 1, 4'd3, 0, 32'h0, 32'h0));
        for (int k = 0; k < 64; k++) begin
            if (!busy_f && !busy_r) break;
            idle(1);
        end
        chk("first_sweep_done", 32'(busy_f | busy_r), 32'd0);

        for (int i = 0; i < 20; i++) apply(tbl[i]);
        idle(4);

        // Reset with preloaded data: sweep length and cleared contents.
        pulse_reset();
        count_busy(nf, nr);
        chk("sweep_len_fwd", 32'(nf), 32'd16);
        chk("sweep_len_rdf", 32'(nr), 32'd16);
        apply(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd5, 1, 32'h0, 32'h0));
        apply(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd7, 1, 32'h0, 32'h0));
        apply(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd2, 1, 32'h0, 32'h0));
        apply(mk(1, 4'hF, 4'd4, 32'hABCD1234, 0, 4'd0, 0, 32'h0, 32'h0));
        idle(4);

        // Reset again nine cycles into the sweep: busy must stay high and restart.
        pulse_reset();
        mf = 0; mr = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clka);
            mf += int'(busy_f);
            mr += int'(busy_r);
        end
        rstb = 1'b1;
        @(posedge clka);
        #1;
        rstb = 1'b0;
        count_busy(nf, nr);
        chk("midreset_busy_fwd", 32'(mf + nf), 32'd25);
        chk("midreset_busy_rdf", 32'(mr + nr), 32'd25);
        for (int a = 0; a < 16; a++)
            apply(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'(a), 1, 32'h0, 32'h0));
        idle(5);

        chk("drain_fwd", 32'(q[0].size()), 32'd0);
        chk("drain_rdf", 32'(q[1].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
